// File: rtl/modulo_arbitro_mux8.sv
// Round-robin arbiter driving the select of an 8:1 mux, with a per-grant hold limit
// and a mandatory idle gap between consecutive grants (break-before-make).
module modulo_arbitro_mux8 #(
   parameter int unsigned HOLD_MAX = 15,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] i_req,
   input  logic       i_release,
   output logic [2:0] o_sel,
   output logic [7:0] o_gnt,
   output logic       o_busy,
   output logic       o_timeout
);

   localparam int unsigned N_REQ = 8;
   localparam int unsigned SEL_W = 3;
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [SEL_W-1:0]   r_sel;
   logic [SEL_W-1:0]   w_sel_nxt;
   logic [SEL_W-1:0]   r_last;
   logic [SEL_W-1:0]   w_last_nxt;
   logic [N_REQ-1:0]   r_gnt;
   logic [N_REQ-1:0]   w_gnt_nxt;
   logic               r_busy;
   logic               w_busy_nxt;
   logic               r_timeout;
   logic               w_timeout_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [SEL_W-1:0]   w_pick;
   logic               w_found;

   // Round-robin search starting just after the last owner; the last owner itself ranks lowest.
   always_comb begin
      w_pick  = '0;
      w_found = 1'b0;
      for (int k = N_REQ; k >= 1; k--) begin
         if (i_req[r_last + SEL_W'(k)]) begin
            w_pick  = r_last + SEL_W'(k);
            w_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_sel     <= '0;
         r_last    <= SEL_W'(N_REQ - 1);
         r_gnt     <= '0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_sel     <= w_sel_nxt;
         r_last    <= w_last_nxt;
         r_gnt     <= w_gnt_nxt;
         r_busy    <= w_busy_nxt;
         r_timeout <= w_timeout_nxt;
         r_cnt     <= w_cnt_nxt;
      end
   end

   // Voluntary exits (release / owner drops its request) take precedence over the hold limit.
   always_comb begin
      w_state_nxt   = r_state;
      w_sel_nxt     = r_sel;
      w_last_nxt    = r_last;
      w_gnt_nxt     = r_gnt;
      w_busy_nxt    = r_busy;
      w_timeout_nxt = 1'b0;
      w_cnt_nxt     = r_cnt;
      case (r_state)
         IDLE: begin
            w_gnt_nxt  = '0;
            w_busy_nxt = 1'b0;
            if (w_found) begin
               w_state_nxt = GRANT;
               w_sel_nxt   = w_pick;
               w_last_nxt  = w_pick;
               w_cnt_nxt   = CNT_W'(1);
               w_gnt_nxt   = N_REQ'(1) << w_pick;
               w_busy_nxt  = 1'b1;
            end
         end
         GRANT: begin
            if (i_release || !i_req[r_sel]) begin
               w_state_nxt = IDLE;
               w_gnt_nxt   = '0;
               w_busy_nxt  = 1'b0;
            end else if (r_cnt >= HOLD_LIM) begin
               w_state_nxt   = IDLE;
               w_gnt_nxt     = '0;
               w_busy_nxt    = 1'b0;
               w_timeout_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign o_sel     = r_sel;
   assign o_gnt     = r_gnt;
   assign o_busy    = r_busy;
   assign o_timeout = r_timeout;

endmodule

// File: tb/tb_modulo_arbitro_mux8.sv
// Directed and randomized checks of modulo_arbitro_mux8 against an owner/hold-count model.
module tb_modulo_arbitro_mux8;

   localparam int HOLD = 4;

   logic       clk;
   logic       rst_n;
   logic [7:0] i_req;
   logic       i_release;
   logic [2:0] o_sel;
   logic [7:0] o_gnt;
   logic       o_busy;
   logic       o_timeout;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference state: current owner (-1 = none), cycles held, last owner, visible select.
   int m_owner;
   int m_held;
   int m_last;
   int m_sel;
   bit m_to;

   modulo_arbitro_mux8 #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     (i_req),
      .i_release (i_release),
      .o_sel     (o_sel),
      .o_gnt     (o_gnt),
      .o_busy    (o_busy),
      .o_timeout (o_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
   endtask

   function automatic logic [7:0] exp_gnt();
      return (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".sel"},     8'(o_sel),     8'(m_sel));
      chk({tag, ".gnt"},     o_gnt,         exp_gnt());
      chk({tag, ".busy"},    8'(o_busy),    8'(m_owner >= 0));
      chk({tag, ".timeout"}, 8'(o_timeout), 8'(m_to));
      chk({tag, ".onehot0"}, 8'($onehot0(o_gnt)), 8'd1);
      chk({tag, ".gntsel"},  8'(o_gnt[o_sel]), 8'(o_busy));
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_last  = 7;
      m_sel   = 0;
      m_to    = 1'b0;
   endtask

   task automatic model_step(input logic [7:0] r, input logic rl);
      if (m_owner < 0) begin
         m_to = 1'b0;
         for (int k = 1; k <= 8; k++) begin
            if (m_owner < 0 && r[(m_last + k) % 8]) begin
               m_owner = (m_last + k) % 8;
               m_last  = m_owner;
               m_sel   = m_owner;
               m_held  = 1;
            end
         end
      end else if (rl || !r[m_owner]) begin
         m_owner = -1;
         m_to    = 1'b0;
      end else if (m_held == HOLD) begin
         m_owner = -1;
         m_to    = 1'b1;
      end else begin
         m_held++;
         m_to = 1'b0;
      end
   endtask

   task automatic step(input logic [7:0] r, input logic rl, input string tag);
      @(negedge clk);
      i_req     = r;
      i_release = rl;
      @(posedge clk);
      model_step(r, rl);
      #1;
      check_all(tag);
   endtask

   // Assert reset between edges so the outputs must clear without any clock.
   task automatic do_reset(input string tag);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      i_req     = 8'h00;
      i_release = 1'b0;
      rst_n     = 1'b1;
   endtask

   logic [7:0] r_rand;
   logic       rl_rand;

   initial begin
      rst_n     = 1'b1;
      i_req     = 8'h00;
      i_release = 1'b0;
      model_reset();

      do_reset("reset");

      // Single requester, release pulse.
      step(8'h01, 1'b0, "r028_grant");
      step(8'h01, 1'b1, "r028_rel");
      step(8'h00, 1'b0, "r028_idle");
      step(8'h00, 1'b1, "idle_release");

      // All requesting, release once per grant: owners rotate with one idle gap each.
      do_reset("reset029");
      for (int g = 0; g < 9; g++) begin
         step(8'hFF, 1'b0, "r029_grant");
         step(8'hFF, 1'b1, "r029_rel");
      end

      // Hold limit with a sole requester, including re-grant of itself.
      do_reset("reset030");
      for (int c = 0; c < 13; c++) step(8'h08, 1'b0, "r030_hold");

      // Release coinciding with the hold limit: no timeout.
      do_reset("reset031");
      for (int c = 0; c < 4; c++) step(8'h08, 1'b0, "r031_hold");
      step(8'h08, 1'b1, "r031_rel");
      step(8'h00, 1'b0, "r031_idle");

      // Owner 5 drops its request while 2 waits.
      step(8'h20, 1'b0, "r032_grant5");
      step(8'h24, 1'b0, "r032_ignore2");
      step(8'h04, 1'b0, "r032_drop");
      step(8'h04, 1'b0, "r032_grant2");
      step(8'h00, 1'b0, "r032_end");

      // Async reset mid-grant, then search restarts at 0.
      step(8'h40, 1'b0, "r033_grant6");
      step(8'h40, 1'b0, "r033_hold6");
      do_reset("r033_reset");
      step(8'h41, 1'b0, "r033_grant0");
      step(8'h41, 1'b1, "r033_rel");
      step(8'h41, 1'b0, "r033_grant6b");

      // Randomized traffic with sticky requests so hold limits are reached.
      r_rand = 8'h00;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 9))
            6, 7:    r_rand = 8'($urandom_range(0, 255));
            8:       r_rand = 8'(1 << $urandom_range(0, 7));
            9:       r_rand = 8'h00;
            default: r_rand = r_rand;
         endcase
         rl_rand = ($urandom_range(0, 5) == 0);
         if (i == 200) do_reset("rand_reset");
         step(r_rand, rl_rand, "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/modulo_arbitro_mux8.md
MODULO_ARBITRO_MUX8 -- requirements
Module: modulo_arbitro_mux8

Interface
REQ-001 Parameter HOLD_MAX, default 15, maximum number of GRANT cycles per grant; legal range 1..255.
REQ-002 Parameter CNT_W, default 8, width of the internal hold counter; CNT_W SHALL hold HOLD_MAX.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  8  request lines; req[i] asks for mux input i.
REQ-006 release  input  1  current owner finished; sampled only in GRANT.
REQ-007 sel  output  3  select code for the 8:1 mux, registered.
REQ-008 gnt  output  8  one-hot grant, registered; all-zero when no owner.
REQ-009 busy  output  1  high while in GRANT.
REQ-010 timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-011 The FSM SHALL have exactly two states, IDLE and GRANT, plus a 3-bit round-robin pointer last (index of the most recent owner).
REQ-012 In IDLE: gnt=0 and busy=0; sel SHALL hold its last value.
REQ-013 In IDLE with req!=0 at an edge, the FSM SHALL enter GRANT at that edge, with sel set to the first i with req[i]=1, searching last+1, last+2, ... mod 8.
REQ-014 Grant latency SHALL be one cycle: a request sampled at edge N gives gnt visible after edge N.
REQ-015 In IDLE with req=0, the FSM SHALL stay in IDLE; last unchanged.
REQ-016 On entering GRANT: last<=chosen index, counter<=1, gnt<=8'b1<<chosen index, busy<=1.
REQ-017 In GRANT: sel and gnt SHALL stay constant; the counter SHALL increment by 1 per cycle, saturating at HOLD_MAX.
REQ-018 GRANT SHALL exit to IDLE at the edge where release=1, or req[sel]=0, or counter==HOLD_MAX.
REQ-019 Exit priority: release or req[sel]=0 first, then the hold limit; timeout SHALL pulse only if the exit is caused by the hold limit alone.
REQ-020 Every grant SHALL be followed by at least one IDLE cycle with gnt=0 (break-before-make on the mux).
REQ-021 Requests from non-owners during GRANT SHALL be ignored until the next IDLE arbitration.
REQ-022 Wrap-around: with last=7 the search SHALL start at 0; a sole requester SHALL be re-granted after the gap, including itself after a timeout.
REQ-023 gnt SHALL be one-hot or zero in every cycle; gnt[sel]=busy in every cycle.
REQ-024 release in IDLE SHALL have no effect.

Reset
REQ-025 rst_n=0 SHALL immediately, without a clock, force: state IDLE, sel=0, gnt=0, busy=0, timeout=0, counter=0, last=7.
REQ-026 Reset asserted mid-GRANT SHALL drop gnt and busy asynchronously; after deassertion the first arbitration SHALL search from index 0.
REQ-027 The first rising edge with rst_n=1 SHALL be able to arbitrate.

Verification
REQ-028 After reset, req=8'h01 -> after the next edge: sel=0, gnt=8'h01, busy=1; release pulse -> gnt=0 next cycle.
REQ-029 req=8'hFF held, release pulsed once per grant -> owners 0,1,2,...,7,0, each grant separated by exactly one gnt=0 cycle.
REQ-030 HOLD_MAX=4, req=8'h08 held, no release -> gnt=8'h08 for 4 cycles, timeout=1 for one cycle at exit, 1 idle cycle, then re-grant of 3.
REQ-031 HOLD_MAX=4, release=1 on the 4th GRANT cycle -> exit, timeout stays 0.
REQ-032 Owner 5 drops req[5] mid-grant while req[2]=1 -> exit next edge, 1 idle cycle, then sel=2, gnt=8'h04.
REQ-033 rst_n pulled low during a grant to 6 -> gnt=0 and sel=0 without a clock; after release with req=8'h41 -> grant to 0 first.
